// File: rtl/wbu_pkg.sv
// Shared types and helpers for the serial-bus input chain.
// Symbol map, length codes, stage-3 select codes and codeword width.
package wbu_pkg;

    localparam int CW_W = 36;

    typedef enum logic [1:0] {
        LC_1 = 2'b00,
        LC_2 = 2'b01,
        LC_4 = 2'b10,
        LC_6 = 2'b11
    } len_code_t;

    typedef enum logic {
        A_IDLE,
        A_COLLECT
    } asm_state_t;

    typedef enum logic [1:0] {
        SEL_PASS,
        SEL_BYP,
        SEL_RAM
    } sel_t;

    typedef struct packed {
        logic       sep;
        logic [5:0] sym;
    } sym_t;

    function automatic sym_t sym_map(input logic [7:0] b);
        sym_t       r;
        logic [7:0] t;
        r.sep = 1'b0;
        t     = 8'h00;
        unique case (1'b1)
            (b >= 8'h30 && b <= 8'h39): t = b - 8'h30;
            (b >= 8'h41 && b <= 8'h5a): t = b - 8'h37;
            (b >= 8'h61 && b <= 8'h7a): t = b - 8'h3d;
            (b == 8'h40):               t = 8'd62;
            (b == 8'h25):               t = 8'd63;
            default: begin
                r.sep = 1'b1;
                t     = 8'h00;
            end
        endcase
        r.sym = t[5:0];
        return r;
    endfunction

    function automatic logic [2:0] sym_count(input len_code_t lc);
        logic [2:0] n;
        unique case (lc)
            LC_1:    n = 3'd1;
            LC_2:    n = 3'd2;
            LC_4:    n = 3'd4;
            default: n = 3'd6;
        endcase
        return n;
    endfunction

    // Symbol idx lands at bits [35-6*idx -: 6] (MSB-first packing).
    function automatic logic [CW_W-1:0] place(
        input logic [CW_W-1:0] word,
        input logic [5:0]      sym,
        input logic [2:0]      idx
    );
        logic [CW_W-1:0] t;
        int              sh;
        t  = {30'd0, sym};
        sh = 30 - 6 * int'(idx);
        return word | (t << sh);
    endfunction

endpackage

// File: rtl/wbusymq.sv
// Synchronous FIFO with full/empty flags, flop storage, head masked to 0 when empty.
// Ports: clk, reset_n, wr_en/wr_data, rd_en/rd_data, empty, full.
module wbusymq #(
    parameter int WIDTH  = 36,
    parameter int LGFLEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int FLEN = 1 << LGFLEN;

    logic [WIDTH-1:0]  mem [FLEN];
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] rd_ptr;
    logic [LGFLEN:0]   count;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (LGFLEN+1)'(FLEN));

    // A push into a full FIFO is still taken when the head pops the same cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wbuinputq.sv
// Byte stream to 36-bit bus codewords with table-reference decompression and output FIFO.
// Ports: i_clk, i_reset_n, i_stb/i_byte in; o_stb/o_codword out, i_busy stall; o_err pulse, o_overflow sticky.
module wbuinputq
    import wbu_pkg::*;
#(
    parameter int LGTBL  = 10,
    parameter int LGFIFO = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_stb,
    input  logic [7:0]      i_byte,
    output logic            o_stb,
    output logic [CW_W-1:0] o_codword,
    input  logic            i_busy,
    output logic            o_err,
    output logic            o_overflow
);

    localparam int TBLN = 1 << LGTBL;
    localparam logic [LGTBL:0] FILL_MAX = (LGTBL+1)'(TBLN);

    // Input capture and symbol map
    logic       r_stb;
    logic [7:0] r_byte;
    logic       s1_stb;
    logic       s1_sep;
    logic [5:0] s1_sym;
    sym_t       map;

    assign map = sym_map(r_byte);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_stb  <= 1'b0;
            r_byte <= 8'h00;
            s1_stb <= 1'b0;
            s1_sep <= 1'b0;
            s1_sym <= 6'd0;
        end else begin
            r_stb  <= i_stb;
            r_byte <= i_byte;
            s1_stb <= r_stb;
            s1_sep <= map.sep;
            s1_sym <= map.sym;
        end
    end

    // Word assembly
    asm_state_t      a_state;
    len_code_t       a_lc;
    logic [2:0]      a_cnt;
    logic [2:0]      a_idx;
    logic [CW_W-1:0] a_word;
    logic [CW_W-1:0] a_next;
    len_code_t       s1_lc;

    logic            s2_vld;
    logic            s2_err;
    logic [CW_W-1:0] s2_word;
    len_code_t       s2_lc;

    assign s1_lc  = len_code_t'(s1_sym[5:4]);
    assign a_next = place(a_word, s1_sym, a_idx);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            a_state <= A_IDLE;
            a_lc    <= LC_1;
            a_cnt   <= 3'd0;
            a_idx   <= 3'd0;
            a_word  <= '0;
            s2_vld  <= 1'b0;
            s2_err  <= 1'b0;
            s2_word <= '0;
            s2_lc   <= LC_1;
        end else begin
            s2_vld <= 1'b0;
            s2_err <= 1'b0;
            if (s1_stb) begin
                unique case (a_state)
                    A_IDLE: begin
                        if (!s1_sep) begin
                            if (s1_lc == LC_1) begin
                                s2_vld  <= 1'b1;
                                s2_word <= {s1_sym, 30'd0};
                                s2_lc   <= LC_1;
                            end else begin
                                a_state <= A_COLLECT;
                                a_lc    <= s1_lc;
                                a_word  <= {s1_sym, 30'd0};
                                a_idx   <= 3'd1;
                                a_cnt   <= sym_count(s1_lc) - 3'd1;
                            end
                        end
                    end
                    default: begin
                        if (s1_sep) begin
                            s2_err  <= 1'b1;
                            a_state <= A_IDLE;
                        end else if (a_cnt == 3'd1) begin
                            s2_vld  <= 1'b1;
                            s2_word <= a_next;
                            s2_lc   <= a_lc;
                            a_state <= A_IDLE;
                        end else begin
                            a_word <= a_next;
                            a_cnt  <= a_cnt - 3'd1;
                            a_idx  <= a_idx + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Decompression history
    logic [CW_W-1:0]  tbl [TBLN];
    logic [CW_W-1:0]  ram_q;
    logic [LGTBL-1:0] wptr;
    logic [LGTBL:0]   fill;
    logic [LGTBL-1:0] offset;
    logic [LGTBL-1:0] rd_addr;
    logic             ref_ok;
    logic             tbl_wr;
    logic [CW_W-1:0]  byp_word;

    logic             s3_vld;
    sel_t             s3_sel;
    logic [CW_W-1:0]  s3_pass;
    logic [CW_W-1:0]  s3_word;
    logic             r_err;

    assign offset  = s2_word[24 +: LGTBL];
    assign ref_ok  = ({1'b0, offset} < fill);
    assign rd_addr = wptr - LGTBL'(1) - offset;
    assign tbl_wr  = s2_vld && (s2_lc == LC_6);

    always_ff @(posedge i_clk) begin
        if (tbl_wr)
            tbl[wptr] <= s2_word;
        ram_q <= tbl[rd_addr];
    end

    // Offset 0 is served from a register holding the newest entry, so the
    // freshest word never depends on RAM read-during-write behaviour.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wptr     <= '0;
            fill     <= '0;
            byp_word <= '0;
            s3_vld   <= 1'b0;
            s3_sel   <= SEL_PASS;
            s3_pass  <= '0;
            r_err    <= 1'b0;
        end else begin
            s3_vld <= 1'b0;
            r_err  <= s2_err;
            if (s2_vld) begin
                unique case (s2_lc)
                    LC_6: begin
                        s3_vld   <= 1'b1;
                        s3_sel   <= SEL_PASS;
                        s3_pass  <= s2_word;
                        byp_word <= s2_word;
                        wptr     <= wptr + 1'b1;
                        if (fill != FILL_MAX)
                            fill <= fill + 1'b1;
                    end
                    LC_2: begin
                        if (ref_ok) begin
                            s3_vld <= 1'b1;
                            s3_sel <= (offset == '0) ? SEL_BYP : SEL_RAM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        s3_vld  <= 1'b1;
                        s3_sel  <= SEL_PASS;
                        s3_pass <= s2_word;
                    end
                endcase
            end
        end
    end

    always_comb begin
        s3_word = s3_pass;
        unique case (s3_sel)
            SEL_RAM: s3_word = ram_q;
            SEL_BYP: s3_word = byp_word;
            default: s3_word = s3_pass;
        endcase
    end

    // Output FIFO
    logic fifo_empty;
    logic fifo_full;
    logic pop;

    assign pop   = o_stb && !i_busy;
    assign o_stb = !fifo_empty;
    assign o_err = r_err;

    wbusymq #(
        .WIDTH  (CW_W),
        .LGFLEN (LGFIFO)
    ) u_fifo (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .wr_en   (s3_vld),
        .wr_data (s3_word),
        .rd_en   (pop),
        .rd_data (o_codword),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            o_overflow <= 1'b0;
        else if (s3_vld && fifo_full && !pop)
            o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_wbuinputq.sv
// Directed vector bench for wbuinputq (LGTBL=4, LGFIFO=2).
// Vector table plus hand sequences for latency, table wrap, FIFO full and reset.
module tb_wbuinputq;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_stb = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_busy = 1'b0;
    logic        o_stb;
    logic [35:0] o_codword;
    logic        o_err;
    logic        o_overflow;

    always #5 i_clk = ~i_clk;

    wbuinputq #(
        .LGTBL  (4),
        .LGFIFO (2)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_stb      (i_stb),
        .i_byte     (i_byte),
        .o_stb      (o_stb),
        .o_codword  (o_codword),
        .i_busy     (i_busy),
        .o_err      (o_err),
        .o_overflow (o_overflow)
    );

    typedef struct {
        bit          rst;
        string       stim;
        int          nout;
        logic [35:0] w0;
        logic [35:0] w1;
        logic [35:0] w2;
        int          nerr;
    } vec_t;

    vec_t        vq[$];
    logic [35:0] got[$];
    int          err_cnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_stb && !i_busy)
                got.push_back(o_codword);
            if (o_err)
                err_cnt++;
        end
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_stb  = 1'b1;
        i_byte = b;
        tick(1);
        i_stb  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    task automatic pulse_reset();
        i_reset_n = 1'b0;
        tick(1);
        i_reset_n = 1'b1;
    endtask

    task automatic clear_obs();
        got.delete();
        err_cnt = 0;
    endtask

    task automatic add(input bit r, input string s, input int n,
                       input logic [35:0] a, input logic [35:0] b,
                       input logic [35:0] c, input int e);
        vec_t v;
        v.rst  = r;
        v.stim = s;
        v.nout = n;
        v.w0   = a;
        v.w1   = b;
        v.w2   = c;
        v.nerr = e;
        vq.push_back(v);
    endtask

    task automatic check_word(input string name, input int idx, input logic [35:0] exp);
        logic [35:0] a;
        a = (idx < got.size()) ? got[idx] : 36'hx;
        check(name, a, exp);
    endtask

    initial begin
        add(1, "z00001\n",        1, 36'hF40000001, 36'h0,         36'h0,         0);
        add(1, "z00001Q0",        2, 36'hF40000001, 36'hF40000001, 36'h0,         0);
        add(1, "Q5",              0, 36'h0,         36'h0,         36'h0,         1);
        add(1, "z0\nz00002",      1, 36'hF40000002, 36'h0,         36'h0,         1);
        add(0, "5 A",             2, 36'h140000000, 36'h280000000, 36'h0,         0);
        add(0, "W123\n",          1, 36'h801083000, 36'h0,         36'h0,         0);
        add(0, "W1*3",            1, 36'h0C0000000, 36'h0,         36'h0,         1);
        add(1, "z00001%a@zZ9Q1",  3, 36'hF40000001, 36'hFE4FBD8C9, 36'hF40000001, 0);
        add(0, "Q2 Q1",           1, 36'hF40000001, 36'h0,         36'h0,         1);
        add(0, "Qz",              0, 36'h0,         36'h0,         36'h0,         1);
        add(0, "\n\n 7\r\n",      1, 36'h1C0000000, 36'h0,         36'h0,         0);

        tick(3);
        i_reset_n = 1'b1;
        pulse_reset();
        check("reset o_stb", 36'(o_stb), 36'd0);
        check("reset o_codword", o_codword, 36'h0);
        check("reset o_err", 36'(o_err), 36'd0);
        check("reset o_overflow", 36'(o_overflow), 36'd0);

        for (int v = 0; v < vq.size(); v++) begin
            if (vq[v].rst)
                pulse_reset();
            clear_obs();
            send_str(vq[v].stim);
            tick(14);
            check($sformatf("v%0d count", v), 36'(got.size()), 36'(vq[v].nout));
            if (vq[v].nout > 0) check_word($sformatf("v%0d w0", v), 0, vq[v].w0);
            if (vq[v].nout > 1) check_word($sformatf("v%0d w1", v), 1, vq[v].w1);
            if (vq[v].nout > 2) check_word($sformatf("v%0d w2", v), 2, vq[v].w2);
            check($sformatf("v%0d errs", v), 36'(err_cnt), 36'(vq[v].nerr));
        end

        // Latency: byte sampled at edge N, o_stb rises after edge N+4
        pulse_reset();
        clear_obs();
        send("5");
        tick(3);
        check("lat o_stb N+3", 36'(o_stb), 36'd0);
        tick(1);
        check("lat o_stb N+4", 36'(o_stb), 36'd1);
        check("lat word", o_codword, 36'h140000000);
        tick(6);

        // Table wrap: 17 writes into 16 entries, then oldest and newest refs
        pulse_reset();
        clear_obs();
        for (int k = 0; k < 17; k++) begin
            send_str("z0000");
            send((k < 10) ? 8'(8'h30 + k) : 8'(8'h41 + k - 10));
            send("\n");
        end
        send_str("QF\nQ0\n");
        tick(14);
        check("wrap count", 36'(got.size()), 36'd19);
        check_word("wrap first", 0, 36'hF40000000);
        check_word("wrap oldest", 17, 36'hF40000001);
        check_word("wrap newest", 18, 36'hF40000010);
        check("wrap errs", 36'(err_cnt), 36'd0);

        // Overflow under backpressure
        pulse_reset();
        clear_obs();
        i_busy = 1'b1;
        send_str("1 2 3 4 5 ");
        tick(14);
        check("ovf flag", 36'(o_overflow), 36'd1);
        check("ovf o_stb", 36'(o_stb), 36'd1);
        check("ovf head", o_codword, 36'h040000000);
        tick(5);
        check("ovf head stable", o_codword, 36'h040000000);
        i_busy = 1'b0;
        tick(10);
        check("ovf drain count", 36'(got.size()), 36'd4);
        for (int k = 0; k < 4; k++)
            check_word($sformatf("ovf drain %0d", k), k, 36'(k + 1) << 30);
        check("ovf sticky", 36'(o_overflow), 36'd1);

        // Reset mid-word with FIFO non-empty
        i_busy = 1'b1;
        send_str("7 z00");
        tick(8);
        check("pre-reset o_stb", 36'(o_stb), 36'd1);
        pulse_reset();
        check("mid reset o_stb", 36'(o_stb), 36'd0);
        check("mid reset o_codword", o_codword, 36'h0);
        check("mid reset o_err", 36'(o_err), 36'd0);
        check("mid reset o_overflow", 36'(o_overflow), 36'd0);
        i_busy = 1'b0;
        clear_obs();
        send_str("Q0 5\n");
        tick(14);
        check("post reset count", 36'(got.size()), 36'd1);
        check_word("post reset word", 0, 36'h140000000);
        check("post reset errs", 36'(err_cnt), 36'd1);

        // Push and pop together on a full FIFO
        pulse_reset();
        clear_obs();
        i_busy = 1'b1;
        send_str("1 2 3 4 ");
        tick(14);
        send("5");
        tick(3);
        i_busy = 1'b0;
        tick(1);
        i_busy = 1'b1;
        check("full pushpop ovf", 36'(o_overflow), 36'd0);
        check("full pushpop head", o_codword, 36'h080000000);
        clear_obs();
        i_busy = 1'b0;
        tick(10);
        check("full pushpop count", 36'(got.size()), 36'd4);
        for (int k = 0; k < 4; k++)
            check_word($sformatf("full pushpop %0d", k), k, 36'(k + 2) << 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
